wb_stage_buf: RTL and testbench

WB_STAGE_BUF -- requirements
Module: wb_stage_buf

---
 rtl/wb_stage_buf_pkg.sv | 14 +
 rtl/wb_stage_buf_if.sv | 14 +
 rtl/wb_stage_buf_fwd.sv | 39 +++
 rtl/wb_stage_buf.sv | 158 +++++++++++++++
 tb/tb_wb_stage_buf.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_buf_pkg.sv
// Shared constants and control encodings for the write-back stage buffer.
package wb_stage_buf_pkg;

    localparam int          STALL_IDX_WB = 4;
    localparam logic [63:0] ZERO_WORD    = 64'd0;
    localparam logic [31:0] NOP_ADDR     = 32'd0;

    typedef enum logic [1:0] {
        WB_ENABLE  = 2'b00,
        WB_DISABLE = 2'b01,
        WB_STOP    = 2'b10
    } wb_ctrl_e;

endpackage

// File: rtl/wb_stage_buf_if.sv
// MEM-stage to write-back handshake: valid/ready plus the register write request.
interface wb_stage_buf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;

    modport master (output in_valid, in_we, in_waddr, in_wdata, input in_ready);
    modport slave  (input in_valid, in_we, in_waddr, in_wdata, output in_ready);
endinterface

// File: rtl/wb_stage_buf_fwd.sv
// Newest-first address match over the live buffer entries, oldest at rd_ptr.
module wb_fwd_match #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] addr_arr [DEPTH],
    input  logic [DATA_W-1:0] data_arr [DEPTH],
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    import wb_stage_buf_pkg::*;

    logic [PTR_W-1:0] idx_s;

    // Walk oldest to newest so a later (newer) match overrides an earlier one.
    always_comb begin
        hit   = 1'b0;
        data  = DATA_W'(ZERO_WORD);
        idx_s = {PTR_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (raddr != ADDR_W'(NOP_ADDR)) &&
                (addr_arr[idx_s] == raddr)) begin
                hit  = 1'b1;
                data = data_arr[idx_s];
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage buffer: holds MEM results while write-back is stalled and
// forwards pending values; drains in strict FIFO order.
module wb_stage_buf
    import wb_stage_buf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 2,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = STALL_IDX_WB,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    wb_stage_buf_if.slave       in_if,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    output logic                wb_we,
    output logic [ADDR_W-1:0]   wb_waddr,
    output logic [DATA_W-1:0]   wb_wdata,
    input  logic [ADDR_W-1:0]   fwd_raddr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [CNT_W-1:0]    count
);

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

    wb_ctrl_e mode_s;
    logic     in_ready_s, useful_s, push_s, pop_s, bypass_s;
    logic     stall_unused_s;

    assign stall_unused_s = ^stall;
    assign in_ready_s     = !rst && !flush && (count_q < CNT_W'(DEPTH));
    assign useful_s       = in_if.in_valid && in_ready_s && in_if.in_we &&
                            (in_if.in_waddr != ADDR_W'(NOP_ADDR));
    assign in_if.in_ready = in_ready_s;

    // Flush dominates the stall bit when deciding what write-back may do.
    always_comb begin
        mode_s = WB_ENABLE;
        if (flush) begin
            mode_s = WB_DISABLE;
        end else if (stall[STALL_IDX]) begin
            mode_s = WB_STOP;
        end else begin
            mode_s = WB_ENABLE;
        end
    end

    // Pop the head when one exists; bypass only an empty buffer so order holds.
    always_comb begin
        pop_s    = 1'b0;
        bypass_s = 1'b0;
        case (mode_s)
            WB_ENABLE: begin
                pop_s    = (count_q != {CNT_W{1'b0}});
                bypass_s = (count_q == {CNT_W{1'b0}}) && useful_s;
            end
            WB_STOP, WB_DISABLE: begin
                pop_s    = 1'b0;
                bypass_s = 1'b0;
            end
            default: begin
                pop_s    = 1'b0;
                bypass_s = 1'b0;
            end
        endcase
        push_s = useful_s && !bypass_s;
    end

    // Next pointer/count state and the value presented on the write port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wb_we_d    = 1'b0;
        wb_waddr_d = ADDR_W'(NOP_ADDR);
        wb_wdata_d = DATA_W'(ZERO_WORD);
        if (mode_s == WB_DISABLE) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
            rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        if (pop_s) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = mem_addr_q[rd_ptr_q];
            wb_wdata_d = mem_data_q[rd_ptr_q];
        end else if (bypass_s) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = in_if.in_waddr;
            wb_wdata_d = in_if.in_wdata;
        end else begin
            wb_we_d    = 1'b0;
            wb_waddr_d = ADDR_W'(NOP_ADDR);
            wb_wdata_d = DATA_W'(ZERO_WORD);
        end
    end

    // Control and write-port registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            wb_we_q    <= 1'b0;
            wb_waddr_q <= ADDR_W'(NOP_ADDR);
            wb_wdata_q <= DATA_W'(ZERO_WORD);
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    // Entry storage; validity is tracked by count only, so no reset here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_addr_q[wr_ptr_q] <= in_if.in_waddr;
            mem_data_q[wr_ptr_q] <= in_if.in_wdata;
        end
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .raddr    (fwd_raddr),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .addr_arr (mem_addr_q),
        .data_arr (mem_data_q),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    assign wb_we    = wb_we_q;
    assign wb_waddr = wb_waddr_q;
    assign wb_wdata = wb_wdata_q;
    assign count    = count_q;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed self-checking bench for wb_stage_buf with hand-computed expectations.
module tb_wb_stage_buf;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [4:0]  fwd_raddr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    wb_stage_buf_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_stage_buf #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(2), .STALL_W(6), .STALL_IDX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (bus),
        .stall     (stall),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .fwd_raddr (fwd_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_we    = we;
        bus.in_waddr = a;
        bus.in_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        stall = 6'd0; flush = 1'b0; fwd_raddr = 5'd0;
        tick(); tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b expected 0", wb_we); end
        checks++; if (wb_waddr !== 5'd0) begin errors++; $display("FAIL reset_wb_waddr: got %0d expected 0", wb_waddr); end
        checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL reset_wb_wdata: got %h expected 0", wb_wdata); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_passthrough();
        drive(1'b1, 1'b1, 5'd5, 32'h1234);
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd5, 32'h1234}) begin errors++; $display("FAIL pass_wb: got we=%b a=%0d d=%h expected we=1 a=5 d=1234", wb_we, wb_waddr, wb_wdata); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL pass_count: got %0d expected 0", count); end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== 38'd0) begin errors++; $display("FAIL pass_bubble: got we=%b a=%0d d=%h expected all zero", wb_we, wb_waddr, wb_wdata); end
    endtask

    task automatic test_stall_queue();
        stall = 6'b010000;
        drive(1'b1, 1'b1, 5'd1, 32'hA);
        tick();
        checks++; if (wb_we !== 1'b0 || count !== 2'd1) begin errors++; $display("FAIL stallq_first: got we=%b count=%0d expected we=0 count=1", wb_we, count); end
        drive(1'b1, 1'b1, 5'd2, 32'hB);
        tick();
        checks++; if (wb_we !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL stallq_second: got we=%b count=%0d expected we=0 count=2", wb_we, count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stallq_full_ready: got %b expected 0", bus.in_ready); end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (wb_we !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL stallq_hold: got we=%b count=%0d expected we=0 count=2", wb_we, count); end
        stall = 6'd0;
        drive(1'b1, 1'b1, 5'd4, 32'hC);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stallq_full_pop_ready: got %b expected 0", bus.in_ready); end
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd1, 32'hA}) begin errors++; $display("FAIL stallq_drain_a: got we=%b a=%0d d=%h expected we=1 a=1 d=a", wb_we, wb_waddr, wb_wdata); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL stallq_drain_a_count: got %0d expected 1", count); end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd2, 32'hB}) begin errors++; $display("FAIL stallq_drain_b: got we=%b a=%0d d=%h expected we=1 a=2 d=b", wb_we, wb_waddr, wb_wdata); end
        tick();
        checks++; if (wb_we !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL stallq_empty: got we=%b count=%0d expected we=0 count=0", wb_we, count); end
    endtask

    task automatic test_back_to_back();
        stall = 6'b010000;
        drive(1'b1, 1'b1, 5'd7, 32'h70);
        tick();
        stall = 6'd0;
        drive(1'b1, 1'b1, 5'd8, 32'h80);
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd7, 32'h70} || count !== 2'd1) begin errors++; $display("FAIL b2b_first: got a=%0d d=%h count=%0d expected a=7 d=70 count=1", wb_waddr, wb_wdata, count); end
        drive(1'b1, 1'b1, 5'd9, 32'h90);
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd8, 32'h80} || count !== 2'd1) begin errors++; $display("FAIL b2b_second: got a=%0d d=%h count=%0d expected a=8 d=80 count=1", wb_waddr, wb_wdata, count); end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd9, 32'h90} || count !== 2'd0) begin errors++; $display("FAIL b2b_third: got a=%0d d=%h count=%0d expected a=9 d=90 count=0", wb_waddr, wb_wdata, count); end
    endtask

    task automatic test_forwarding();
        stall = 6'b010000;
        drive(1'b1, 1'b1, 5'd3, 32'h11);
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'h22);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        fwd_raddr = 5'd3;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin errors++; $display("FAIL fwd_newest: got hit=%b d=%h expected hit=1 d=22", fwd_hit, fwd_data); end
        fwd_raddr = 5'd0;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_zero_addr: got hit=%b d=%h expected hit=0 d=0", fwd_hit, fwd_data); end
        fwd_raddr = 5'd7;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_miss: got hit=%b d=%h expected hit=0 d=0", fwd_hit, fwd_data); end
        stall = 6'd0;
        fwd_raddr = 5'd3;
        tick();
        checks++; if (wb_wdata !== 32'h11 || fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin errors++; $display("FAIL fwd_after_pop: got wb=%h hit=%b d=%h expected wb=11 hit=1 d=22", wb_wdata, fwd_hit, fwd_data); end
        tick();
        checks++; if (wb_wdata !== 32'h22 || fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_empty: got wb=%h hit=%b d=%h expected wb=22 hit=0 d=0", wb_wdata, fwd_hit, fwd_data); end
        fwd_raddr = 5'd0;
        tick();
    endtask

    task automatic test_filtering();
        stall = 6'b010000;
        drive(1'b1, 1'b0, 5'd6, 32'h66);
        tick();
        checks++; if (count !== 2'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL filt_we0: got count=%0d ready=%b expected count=0 ready=1", count, bus.in_ready); end
        drive(1'b1, 1'b1, 5'd0, 32'h77);
        tick();
        checks++; if (count !== 2'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL filt_addr0: got count=%0d ready=%b expected count=0 ready=1", count, bus.in_ready); end
        stall = 6'b101111;
        drive(1'b1, 1'b0, 5'd6, 32'h66);
        tick();
        checks++; if (wb_we !== 1'b0 || wb_wdata !== 32'd0) begin errors++; $display("FAIL filt_nobypass_we0: got we=%b d=%h expected we=0 d=0", wb_we, wb_wdata); end
        drive(1'b1, 1'b1, 5'd0, 32'h77);
        tick();
        checks++; if (wb_we !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL filt_nobypass_addr0: got we=%b count=%0d expected we=0 count=0", wb_we, count); end
        stall = 6'd0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_flush();
        stall = 6'b010000;
        drive(1'b1, 1'b1, 5'd10, 32'hAA);
        tick();
        drive(1'b1, 1'b1, 5'd11, 32'hBB);
        tick();
        stall = 6'd0;
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd15, 32'hFF);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
        tick();
        checks++; if (count !== 2'd0 || {wb_we, wb_waddr, wb_wdata} !== 38'd0) begin errors++; $display("FAIL flush_clear: got count=%0d we=%b a=%0d d=%h expected all zero", count, wb_we, wb_waddr, wb_wdata); end
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (wb_we !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL flush_after: got we=%b count=%0d expected we=0 count=0", wb_we, count); end
        stall = 6'b010000;
        drive(1'b1, 1'b1, 5'd12, 32'hCC);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        stall = 6'd0;
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd12, 32'hCC}) begin errors++; $display("FAIL flush_refill: got we=%b a=%0d d=%h expected we=1 a=12 d=cc", wb_we, wb_waddr, wb_wdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        stall = 6'b010000;
        drive(1'b1, 1'b1, 5'd13, 32'hDD);
        tick();
        drive(1'b1, 1'b1, 5'd14, 32'hEE);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        stall = 6'd0;
        tick();
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd13, 32'hDD} || count !== 2'd1) begin errors++; $display("FAIL rstmid_pre: got a=%0d d=%h count=%0d expected a=13 d=dd count=1", wb_waddr, wb_wdata, count); end
        rst = 1'b1;
        #1;
        checks++; if ({wb_we, wb_waddr, wb_wdata} !== 38'd0 || count !== 2'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_async: got we=%b a=%0d d=%h count=%0d ready=%b expected all zero", wb_we, wb_waddr, wb_wdata, count, bus.in_ready); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wb_we !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL rstmid_drain%0d: got we=%b count=%0d expected we=0 count=0", i, wb_we, count); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_stall_queue();
        test_back_to_back();
        test_forwarding();
        test_filtering();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
